timer_sched: RTL
================

# timer_sched

Multi-channel timeout scheduler that owns and shares one programmable tick timer among CHANNELS requesters. Configures the timer's ceiling (tick rate), arms per-channel tick countdowns through a valid/ready handshake, and reports expiries as a round-robin-arbitrated event stream. Sits between the free-running tick timer and the host-side command/response logic.

## Interface
- CHANNELS, 4: number of independent countdown channels (2..16).
- COUNT_WIDTH, 8: width of per-channel tick count.
- CEILING_WIDTH, 4: width of ceiling value driven to the timer.
- DEFAULT_CEILING, 0: ceiling_out value after reset.

- clk_in  input  1  system clock; all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- ceiling_out  output  CEILING_WIDTH  ceiling to tick timer (registered).
- tick_in  input  1  single-cycle tick pulse from timer.
- cfg_valid_in  input  1  ceiling update request.
- cfg_ceiling_in  input  CEILING_WIDTH  new ceiling.
- cfg_ready_out  output  1  ceiling update accepted when high with cfg_valid_in.
- arm_valid_in  input  1  arm request.
- arm_chan_in  input  clog2(CHANNELS)  channel to arm.
- arm_count_in  input  COUNT_WIDTH  ticks until expiry.
- arm_ready_out  output  1  arm accepted when high with arm_valid_in.
- cancel_in  input  CHANNELS  per-channel cancel, level-sampled each cycle.
- busy_out  output  CHANNELS  channel state != IDLE.
- evt_valid_out  output  1  expiry event available (registered).
- evt_chan_out  output  clog2(CHANNELS)  expired channel (registered).
- evt_ready_in  input  1  event consumer ready.

## Operation
- Per-channel FSM: IDLE -> ARMED (arm accepted, count != 0) or PENDING (arm accepted, count == 0); ARMED -> PENDING on tick_in with count == 1; ARMED -> IDLE on cancel_in; PENDING -> IDLE when its event is accepted (evt_valid_out & evt_ready_in).
- Tick: every ARMED channel decrements count by 1 (count >= 2) or goes PENDING (count == 1). Count never wraps.
- Arm same cycle as tick on that channel: loaded count wins, tick not applied.
- Cancel: ARMED only; ignored in IDLE and PENDING (an expiry, once pending, is always reported). Arm and cancel same channel same cycle: arm wins.
- arm_ready_out = !reset_in & (state[arm_chan_in] == IDLE). arm_chan_in >= CHANNELS: arm_ready_out = 0.
- cfg_ready_out = !reset_in & no channel ARMED & no arm accepted this cycle. Accepted cfg loads ceiling_out next cycle. Ceiling never changes while any countdown is live.
- Event arbiter: round-robin over PENDING channels, search starting at pointer rr; on grant of channel k, rr <= (k+1) mod CHANNELS. evt_valid_out/evt_chan_out hold stable until accepted. Channel being accepted this cycle is excluded from next selection, so back-to-back events need no bubble.

## Timing
- Reset (reset_in high at edge): all channels IDLE, counts 0, rr = 0, evt_valid_out = 0, evt_chan_out = 0, ceiling_out = DEFAULT_CEILING, busy_out = 0; arm_ready_out and cfg_ready_out = 0 while reset_in high. Reset mid-countdown or mid-event discards all state; no event emitted.
- Arm with count N accepted at edge e: busy_out high after e; PENDING at edge of the Nth subsequent tick_in pulse; evt_valid_out high one cycle after PENDING (if arbiter idle).
- Arm with count 0 at edge e: PENDING after e, evt_valid_out after e+1.
- Event accepted at edge a: channel IDLE and busy_out low after a; next pending channel (if any) presented after a.
- evt_ready_in low: events queue in PENDING; no loss, no duplicates.

## Test plan
- Reset, cfg ceiling 5 with all idle -> cfg_ready_out 1, ceiling_out = 5 next cycle; arm ch1 count 3 then cfg -> cfg_ready_out 0 until ch1 leaves ARMED.
- Arm ch2 count 3, pulse tick_in 3 times, evt_ready_in 1 -> evt_valid_out one cycle after third tick's PENDING, evt_chan_out = 2, busy_out[2] low after accept.
- Arm ch0..ch3 count 1, one tick, evt_ready_in held 1 -> events ch0,ch1,ch2,ch3 on four consecutive cycles; repeat with rr = 2 -> order 2,3,0,1.
- Arm ch1 count 4, cancel_in[1] after 2 ticks -> busy_out[1] low, no event; arm ch1 again -> arm_ready_out 1.
- evt_ready_in 0 with ch0, ch3 pending -> evt_valid_out 1, evt_chan_out stable at 0 for 10 cycles; arm ch0 -> arm_ready_out 0; cancel ch3 ignored.
- Arm ch2 count 0 -> event ch2 two cycles later; reset_in asserted while evt_valid_out 1 -> evt_valid_out 0, all busy_out 0 next cycle.

Source files
------------

// File: rtl/timer_sched_if.sv
// Host-side handshakes of the timeout scheduler:
// ceiling config, channel arm and expiry event stream.
interface timer_sched_if #(
    parameter int CHANNELS      = 4,
    parameter int COUNT_WIDTH   = 8,
    parameter int CEILING_WIDTH = 4
);
    localparam int CW = $clog2(CHANNELS);

    logic                     cfg_valid_in;
    logic [CEILING_WIDTH-1:0] cfg_ceiling_in;
    logic                     cfg_ready_out;

    logic                     arm_valid_in;
    logic [CW-1:0]            arm_chan_in;
    logic [COUNT_WIDTH-1:0]   arm_count_in;
    logic                     arm_ready_out;

    logic                     evt_valid_out;
    logic [CW-1:0]            evt_chan_out;
    logic                     evt_ready_in;

    modport slave (
        input  cfg_valid_in, cfg_ceiling_in,
        input  arm_valid_in, arm_chan_in, arm_count_in,
        input  evt_ready_in,
        output cfg_ready_out, arm_ready_out,
        output evt_valid_out, evt_chan_out
    );

    modport master (
        output cfg_valid_in, cfg_ceiling_in,
        output arm_valid_in, arm_chan_in, arm_count_in,
        output evt_ready_in,
        input  cfg_ready_out, arm_ready_out,
        input  evt_valid_out, evt_chan_out
    );
endinterface

// File: rtl/timer_sched.sv
// Multi-channel timeout scheduler sharing one tick timer;
// expiries leave through a round-robin event stream.
module timer_sched #(
    parameter int CHANNELS      = 4,
    parameter int COUNT_WIDTH   = 8,
    parameter int CEILING_WIDTH = 4,
    parameter logic [CEILING_WIDTH-1:0] DEFAULT_CEILING = '0
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     tick_in,
    input  logic [CHANNELS-1:0]      cancel_in,
    output logic [CEILING_WIDTH-1:0] ceiling_out,
    output logic [CHANNELS-1:0]      busy_out,
    timer_sched_if.slave             bus
);
    localparam int CW = $clog2(CHANNELS);

    typedef enum logic [1:0] {IDLE, ARMED, PENDING} state_t;

    state_t                 state [CHANNELS];
    logic [COUNT_WIDTH-1:0] count [CHANNELS];
    logic [CW-1:0]          rr;

    logic                arm_hit;
    logic                arm_fire;
    logic                any_armed;
    logic                evt_fire;
    logic                sel_found;
    logic [CW-1:0]       sel_chan;
    logic [CHANNELS-1:0] pend;

    assign evt_fire = bus.evt_valid_out & bus.evt_ready_in;

    // The channel being accepted now is masked out so the next
    // event can be presented without a bubble.
    always_comb begin
        arm_hit   = 1'b0;
        any_armed = 1'b0;
        pend      = '0;
        busy_out  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.arm_chan_in == CW'(i) && state[i] == IDLE)
                arm_hit = 1'b1;
            if (state[i] == ARMED)
                any_armed = 1'b1;
            pend[i] = (state[i] == PENDING) &&
                      !(evt_fire && bus.evt_chan_out == CW'(i));
            busy_out[i] = (state[i] != IDLE);
        end
    end

    assign bus.arm_ready_out = !reset_in & arm_hit;
    assign arm_fire = bus.arm_valid_in & bus.arm_ready_out;
    assign bus.cfg_ready_out = !reset_in & !any_armed & !arm_fire;

    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!sel_found && pend[(int'(rr) + k) % CHANNELS]) begin
                sel_found = 1'b1;
                sel_chan  = CW'((int'(rr) + k) % CHANNELS);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= IDLE;
                count[i] <= '0;
            end
            rr                <= '0;
            bus.evt_valid_out <= 1'b0;
            bus.evt_chan_out  <= '0;
            ceiling_out       <= DEFAULT_CEILING;
        end else begin
            if (bus.cfg_valid_in && bus.cfg_ready_out)
                ceiling_out <= bus.cfg_ceiling_in;
            for (int i = 0; i < CHANNELS; i++) begin
                unique case (state[i])
                    IDLE: begin
                        if (arm_fire && bus.arm_chan_in == CW'(i)) begin
                            count[i] <= bus.arm_count_in;
                            state[i] <= (bus.arm_count_in == '0) ?
                                        PENDING : ARMED;
                        end
                    end
                    ARMED: begin
                        if (cancel_in[i]) begin
                            state[i] <= IDLE;
                            count[i] <= '0;
                        end else if (tick_in) begin
                            if (count[i] == COUNT_WIDTH'(1)) begin
                                state[i] <= PENDING;
                                count[i] <= '0;
                            end else begin
                                count[i] <= count[i] - 1'b1;
                            end
                        end
                    end
                    PENDING: begin
                        if (evt_fire && bus.evt_chan_out == CW'(i))
                            state[i] <= IDLE;
                    end
                    default: state[i] <= IDLE;
                endcase
            end
            if (!bus.evt_valid_out || evt_fire) begin
                bus.evt_valid_out <= sel_found;
                if (sel_found) begin
                    bus.evt_chan_out <= sel_chan;
                    rr <= CW'((int'(sel_chan) + 1) % CHANNELS);
                end
            end
        end
    end
endmodule
